// File: rtl/lane_sched_pkg.sv
// lane_sched_pkg: shared sizes and helpers for the lane scheduler
package lane_sched_pkg;
  localparam int NUM_LANES = 4;
  localparam int DATA_W = 8;
  localparam int PHASE_W = 3;
  localparam int SLOT_LEN = 4;
  localparam int IDX_W = $clog2(NUM_LANES);
  localparam int SLOT_W = $clog2(SLOT_LEN);
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [IDX_W-1:0] x);
    return NUM_LANES'(1) << x;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational circular search for the first eligible lane at or above rr_ptr
// eligible - lanes that may be granted; rr_ptr - lane to try first
// found    - some lane is eligible;   idx    - chosen lane (valid when found)
module rr_pick4
  import lane_sched_pkg::*;
(
  input  logic [NUM_LANES-1:0] eligible,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);
  logic [NUM_LANES-1:0] rot;
  logic [IDX_W-1:0]     off;
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_LANES; i++) rot[i] = eligible[rr_ptr + IDX_W'(i)];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    idx = rr_ptr + off;
    found = |eligible;
  end
endmodule

// File: rtl/lane_scheduler.sv
// lane_scheduler: 4-lane round-robin slot scheduler, one grant per 4-cycle slot
// clk8f, reset (sync, active-low); lane_en/req - per-lane enable and request
// data_in0..3 - lane payloads; data_out/valid_out/lane_id - granted byte, held a whole slot
// ack - one-cycle one-hot grant; phase - frame down-counter; slot_start - first cycle of a slot
module lane_scheduler
  import lane_sched_pkg::*;
(
  input  logic                 clk8f,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [NUM_LANES-1:0] req,
  input  logic [DATA_W-1:0]    data_in0,
  input  logic [DATA_W-1:0]    data_in1,
  input  logic [DATA_W-1:0]    data_in2,
  input  logic [DATA_W-1:0]    data_in3,
  output logic [DATA_W-1:0]    data_out,
  output logic                 valid_out,
  output logic [IDX_W-1:0]     lane_id,
  output logic [NUM_LANES-1:0] ack,
  output logic [PHASE_W-1:0]   phase,
  output logic                 slot_start
);
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0]    data_q, data_d, sel;
  logic                 valid_q, valid_d, found, decide;
  logic [IDX_W-1:0]     lane_q, lane_d, rr_q, rr_d, idx;
  logic [NUM_LANES-1:0] ack_q, ack_d, eligible;
  rr_pick4 u_pick (
    .eligible(eligible),
    .rr_ptr  (rr_q),
    .found   (found),
    .idx     (idx)
  );
  // Decisions happen when the low phase bits are zero, so the slot's outputs
  // appear exactly when phase wraps to the slot's first value (7 or 3).
  always_comb begin
    eligible = req & lane_en;
    decide = phase_q[SLOT_W-1:0] == '0;
    sel = idx == 2'd0 ? data_in0 : idx == 2'd1 ? data_in1 : idx == 2'd2 ? data_in2 : data_in3;
    phase_d = phase_q - PHASE_W'(1);
    valid_d = decide ? found : valid_q;
    lane_d = decide ? (found ? idx : '0) : lane_q;
    data_d = decide ? (found ? sel : '0) : data_q;
    ack_d = decide && found ? lane_onehot(idx) : '0;
    rr_d = decide && found ? idx + IDX_W'(1) : rr_q;
  end
  always_ff @(posedge clk8f) begin
    if (!reset) begin
      phase_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      lane_q <= '0;
      ack_q <= '0;
      rr_q <= '0;
    end else begin
      phase_q <= phase_d;
      data_q <= data_d;
      valid_q <= valid_d;
      lane_q <= lane_d;
      ack_q <= ack_d;
      rr_q <= rr_d;
    end
  end
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign lane_id = lane_q;
  assign ack = ack_q;
  assign phase = phase_q;
  assign slot_start = phase_q[SLOT_W-1:0] == SLOT_W'(SLOT_LEN - 1);
endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: directed slot-level vectors plus hand sequences for late request and mid-slot reset
module tb_lane_scheduler;
  logic       clk8f, reset;
  logic [3:0] lane_en, req, ack;
  logic [7:0] data_in0, data_in1, data_in2, data_in3, data_out;
  logic       valid_out, slot_start;
  logic [1:0] lane_id;
  logic [2:0] phase, exp_phase;
  int n_vec, n_bad;
  typedef struct packed {
    logic [3:0] en;
    logic [3:0] rq;
    logic       v;
    logic [1:0] l;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[17];
  lane_scheduler dut (
    .clk8f(clk8f), .reset(reset), .lane_en(lane_en), .req(req),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out(data_out), .valid_out(valid_out), .lane_id(lane_id), .ack(ack),
    .phase(phase), .slot_start(slot_start)
  );
  initial clk8f = 1'b0;
  always #5 clk8f = ~clk8f;
  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask
  task automatic cyc(input bit v, input logic [1:0] l, input logic [7:0] d, input logic [3:0] a);
    bit r;
    r = reset;
    @(posedge clk8f);
    #1;
    exp_phase = r ? exp_phase - 3'd1 : 3'd0;
    chk("phase", int'(phase), int'(exp_phase));
    chk("slot_start", int'(slot_start), int'(exp_phase == 3'd7 || exp_phase == 3'd3));
    chk("valid_out", int'(valid_out), int'(v));
    chk("lane_id", int'(lane_id), int'(l));
    chk("data_out", int'(data_out), int'(d));
    chk("ack", int'(ack), int'(a));
  endtask
  task automatic slot(input logic [3:0] en, input logic [3:0] rq, input bit v,
                      input logic [1:0] l, input logic [7:0] d);
    lane_en = en;
    req = rq;
    cyc(v, l, d, v ? 4'b0001 << l : 4'b0000);
    repeat (3) cyc(v, l, d, 4'b0000);
  endtask
  initial begin
    n_vec = 0;
    n_bad = 0;
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 2'd0, 8'hA0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 2'd1, 8'hB1};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 2'd2, 8'hC2};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 2'd3, 8'hD3};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 2'd0, 8'hA0};
    tbl[5]  = '{4'hF, 4'h5, 1'b1, 2'd2, 8'hC2};
    tbl[6]  = '{4'hF, 4'h5, 1'b1, 2'd0, 8'hA0};
    tbl[7]  = '{4'hF, 4'h5, 1'b1, 2'd2, 8'hC2};
    tbl[8]  = '{4'hF, 4'h5, 1'b1, 2'd0, 8'hA0};
    tbl[9]  = '{4'h2, 4'hF, 1'b1, 2'd1, 8'hB1};
    tbl[10] = '{4'h2, 4'hF, 1'b1, 2'd1, 8'hB1};
    tbl[11] = '{4'h2, 4'hF, 1'b1, 2'd1, 8'hB1};
    tbl[12] = '{4'h0, 4'hF, 1'b0, 2'd0, 8'h00};
    tbl[13] = '{4'hF, 4'h8, 1'b1, 2'd3, 8'hD3};
    tbl[14] = '{4'hC, 4'h3, 1'b0, 2'd0, 8'h00};
    tbl[15] = '{4'hF, 4'h6, 1'b1, 2'd1, 8'hB1};
    tbl[16] = '{4'hF, 4'h6, 1'b1, 2'd2, 8'hC2};
    reset = 1'b0;
    lane_en = 4'h0;
    req = 4'h0;
    data_in0 = 8'hA0;
    data_in1 = 8'hB1;
    data_in2 = 8'hC2;
    data_in3 = 8'hD3;
    exp_phase = 3'd0;
    repeat (3) cyc(1'b0, 2'd0, 8'h00, 4'h0);
    reset = 1'b1;
    repeat (2) slot(4'hF, 4'h0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 17; i++) slot(tbl[i].en, tbl[i].rq, tbl[i].v, tbl[i].l, tbl[i].d);
    lane_en = 4'hF;
    req = 4'h0;
    cyc(1'b0, 2'd0, 8'h00, 4'h0);
    req = 4'h8;
    repeat (3) cyc(1'b0, 2'd0, 8'h00, 4'h0);
    cyc(1'b1, 2'd3, 8'hD3, 4'h8);
    req = 4'h0;
    repeat (3) cyc(1'b1, 2'd3, 8'hD3, 4'h0);
    req = 4'hF;
    cyc(1'b1, 2'd0, 8'hA0, 4'h1);
    reset = 1'b0;
    cyc(1'b0, 2'd0, 8'h00, 4'h0);
    reset = 1'b1;
    cyc(1'b1, 2'd0, 8'hA0, 4'h1);
    repeat (3) cyc(1'b1, 2'd0, 8'hA0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
